// File: rtl/float_result_buffer_if.sv
// Valid/ready stream carrying one float_alu result word plus its IEEE exception flags.
// The master drives valid/result/flags and the slave drives ready.
interface float_result_buffer_if;
  logic        valid;
  logic        ready;
  logic [31:0] result;
  logic [4:0]  flags;

  modport master (output valid, output result, output flags, input ready);
  modport slave  (input valid, input result, input flags, output ready);
endinterface

// File: rtl/float_result_buffer.sv
// Result FIFO behind float_alu with first-word fall-through output, sticky fflags-style
// exception accumulation and a one-cycle event pulse on the first set of a masked flag.
module float_result_buffer #(
  parameter int         DEPTH    = 4,
  parameter logic [4:0] IRQ_MASK = 5'b00101
) (
  input  logic                      clk,
  input  logic                      rst,
  float_result_buffer_if.slave      in_if,
  float_result_buffer_if.master     out_if,
  output logic [$clog2(DEPTH):0]    count,
  output logic [4:0]                sticky_flags,
  input  logic                      sticky_clr,
  output logic                      flag_irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   result_mem [DEPTH];
  logic [4:0]    flags_mem  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [4:0]    sticky_base;

  // Ready is derived only from registered occupancy, so a full buffer never accepts
  // even when the consumer pops in the same cycle.
  assign in_if.ready   = !rst && (count != FULL);
  assign out_if.valid  = (count != '0);
  assign push          = in_if.valid && in_if.ready;
  assign pop           = out_if.valid && out_if.ready;
  assign out_if.result = result_mem[rd_ptr];
  assign out_if.flags  = flags_mem[rd_ptr];

  // A clear in the same cycle means this push's flags are compared against an empty history.
  assign sticky_base = sticky_clr ? 5'b00000 : sticky_flags;

  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr] <= in_if.result;
      flags_mem[wr_ptr]  <= in_if.flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
      flag_irq     <= 1'b0;
    end else begin
      if (push)            sticky_flags <= sticky_base | in_if.flags;
      else if (sticky_clr) sticky_flags <= '0;
      flag_irq <= push && (|(in_if.flags & IRQ_MASK & ~sticky_base));
    end
  end

endmodule

// File: tb/tb_float_result_buffer.sv
// Directed bench for float_result_buffer: reset, pass-through, fill/backpressure,
// streaming with pointer wrap, sticky/irq behaviour, clear collision and mid-stream reset.
module tb_float_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sticky_clr;
  logic [2:0] count;
  logic [4:0] sticky_flags;
  logic       flag_irq;
  int         checks = 0;
  int         errors = 0;

  float_result_buffer_if in_bus ();
  float_result_buffer_if out_bus ();

  float_result_buffer #(.DEPTH(4), .IRQ_MASK(5'b00101)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (in_bus),
    .out_if       (out_bus),
    .count        (count),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .flag_irq     (flag_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] f);
    in_bus.valid  = v;
    in_bus.result = r;
    in_bus.flags  = f;
  endtask

  initial begin
    rst = 1'b1;
    sticky_clr = 1'b0;
    out_bus.ready = 1'b0;
    drive(1'b0, 32'h0, 5'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_bus.valid), 32'd0);
    chk("reset_sticky", 32'(sticky_flags), 32'd0);
    chk("reset_irq", 32'(flag_irq), 32'd0);
    chk("reset_in_ready", 32'(in_bus.ready), 32'd1);

    // Single result straight through to a ready consumer
    out_bus.ready = 1'b1;
    drive(1'b1, 32'h423AC000, 5'b00000);
    tick();
    drive(1'b0, 32'h0, 5'b0);
    chk("single_valid", 32'(out_bus.valid), 32'd1);
    chk("single_result", out_bus.result, 32'h423AC000);
    chk("single_flags", 32'(out_bus.flags), 32'd0);
    chk("single_count1", 32'(count), 32'd1);
    tick();
    chk("single_count0", 32'(count), 32'd0);
    chk("single_valid0", 32'(out_bus.valid), 32'd0);
    chk("single_sticky", 32'(sticky_flags), 32'd0);
    chk("single_irq", 32'(flag_irq), 32'd0);

    // Fill to full, then hold a fifth word under backpressure
    out_bus.ready = 1'b0;
    drive(1'b1, 32'h423AC000, 5'b0); tick();
    drive(1'b1, 32'hC32B8000, 5'b0); tick();
    drive(1'b1, 32'h42861000, 5'b0); tick();
    drive(1'b1, 32'h42C24000, 5'b0); tick();
    chk("fill_count4", 32'(count), 32'd4);
    chk("fill_in_ready0", 32'(in_bus.ready), 32'd0);
    drive(1'b1, 32'h7F800000, 5'b0);
    tick();
    chk("hold_count4", 32'(count), 32'd4);
    chk("hold_in_ready0", 32'(in_bus.ready), 32'd0);
    chk("hold_head", out_bus.result, 32'h423AC000);
    out_bus.ready = 1'b1;
    tick();
    chk("drain_count3", 32'(count), 32'd3);
    chk("drain_in_ready1", 32'(in_bus.ready), 32'd1);
    chk("drain_head1", out_bus.result, 32'hC32B8000);
    tick();
    drive(1'b0, 32'h0, 5'b0);
    chk("drain_count_pp", 32'(count), 32'd3);
    chk("drain_head2", out_bus.result, 32'h42861000);
    tick();
    chk("drain_head3", out_bus.result, 32'h42C24000);
    tick();
    chk("drain_head4", out_bus.result, 32'h7F800000);
    chk("drain_count1", 32'(count), 32'd1);
    tick();
    chk("drain_empty", 32'(count), 32'd0);

    // Stream at occupancy 2; ten pushes wrap the 2-bit pointers twice
    out_bus.ready = 1'b0;
    drive(1'b1, 32'h10000000, 5'b0); tick();
    drive(1'b1, 32'h10000001, 5'b0); tick();
    chk("stream_pre_count", 32'(count), 32'd2);
    out_bus.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10000002 + 32'(i), 5'b0);
      tick();
      chk($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
      chk($sformatf("stream_head_%0d", i), out_bus.result, 32'h10000001 + 32'(i));
    end
    drive(1'b0, 32'h0, 5'b0);
    tick();
    chk("stream_tail", out_bus.result, 32'h10000009);
    tick();
    chk("stream_empty", 32'(count), 32'd0);

    // Sticky accumulation and first-time irq on masked bits only
    drive(1'b1, 32'h3CA3D70B, 5'b10000);
    tick();
    chk("sticky_x", 32'(sticky_flags), 32'h10);
    chk("irq_x_unmasked", 32'(flag_irq), 32'd0);
    drive(1'b1, 32'h7F800000, 5'b10100);
    tick();
    chk("sticky_xo", 32'(sticky_flags), 32'h14);
    chk("irq_overflow", 32'(flag_irq), 32'd1);
    drive(1'b0, 32'h0, 5'b0);
    tick();
    chk("irq_one_cycle", 32'(flag_irq), 32'd0);
    drive(1'b1, 32'h7FC00000, 5'b00001);
    tick();
    chk("irq_invalid", 32'(flag_irq), 32'd1);
    chk("sticky_xoi", 32'(sticky_flags), 32'h15);
    drive(1'b1, 32'h7F800000, 5'b00100);
    tick();
    chk("irq_repeat", 32'(flag_irq), 32'd0);
    chk("sticky_repeat", 32'(sticky_flags), 32'h15);

    // Clear collides with a push: new flags win
    sticky_clr = 1'b1;
    drive(1'b1, 32'h00800000, 5'b00010);
    tick();
    chk("clr_push_sticky", 32'(sticky_flags), 32'h02);
    chk("clr_push_irq", 32'(flag_irq), 32'd0);
    drive(1'b0, 32'h0, 5'b0);
    tick();
    sticky_clr = 1'b0;
    chk("clr_alone", 32'(sticky_flags), 32'd0);
    tick();
    chk("clr_drained", 32'(count), 32'd0);

    // Reset with three queued entries and a held input
    out_bus.ready = 1'b0;
    drive(1'b1, 32'hAAAA0001, 5'b00001); tick();
    drive(1'b1, 32'hAAAA0002, 5'b00000); tick();
    drive(1'b1, 32'hAAAA0003, 5'b00000); tick();
    chk("rst_pre_count", 32'(count), 32'd3);
    chk("rst_pre_sticky", 32'(sticky_flags), 32'h01);
    drive(1'b1, 32'h55AA55AA, 5'b00000);
    rst = 1'b1;
    #1;
    chk("rst_in_ready0", 32'(in_bus.ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_count0", 32'(count), 32'd0);
    chk("rst_out_valid0", 32'(out_bus.valid), 32'd0);
    chk("rst_sticky0", 32'(sticky_flags), 32'd0);
    chk("rst_in_ready1", 32'(in_bus.ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 5'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_head", out_bus.result, 32'h55AA55AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_result_buffer.md
Name: float_result_buffer

Overview:
- Downstream stage of float_alu. Accepts each completed {result, flags} from the ALU's valid_out/ready_in handshake and queues it in a small FIFO for a consumer with its own valid/ready handshake.
- Applies backpressure to the ALU through its ready_in when the FIFO is full.
- Keeps a sticky, clearable accumulation of IEEE exception flags, similar to fflags.
- Pulses an event output when a masked flag becomes set for the first time.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- IRQ_MASK, 5'b00101, flag bits that raise flag_irq on a first-time set. Default is overflow and invalid.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result valid; connects to float_alu valid_out.
- in_ready  out  1  buffer can accept; connects to float_alu ready_in.
- in_result  in  32  ALU result word.
- in_flags  in  5  ALU flags: [4] X inexact, [3] Z div-by-zero, [2] O overflow, [1] U underflow, [0] I invalid.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_result  out  32  head result.
- out_flags  out  5  head flags.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- sticky_flags  out  5  OR of the flags of all accepted results since the last reset/clear.
- sticky_clr  in  1  clears sticky_flags.
- flag_irq  out  1  one-cycle pulse on a first-time set of a masked sticky bit.

Behaviour:
Reset (rst high at posedge):
- wr_ptr, rd_ptr, count, sticky_flags and flag_irq go to 0.
- FIFO storage contents are don't-care.
- in_ready is combinationally 0 during any cycle with rst high.
- Any push or pop presented in a reset cycle is ignored, including reset mid-stream (queued data is discarded).

Push and pop:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = !rst & (count != DEPTH). It is combinational from registered count and does not depend on out_ready, so there is no push-through when full.
- out_valid = (count != 0).
- out_result/out_flags = mem[rd_ptr], first-word fall-through. They are stable while out_valid & !out_ready.

Latency and throughput:
- An entry pushed at edge N is visible on out_* after edge N, i.e. one cycle; there is no same-cycle bypass when empty.
- Sustained throughput is 1 push and 1 pop per cycle when 0 < count < DEPTH.

Occupancy and pointers:
- count: push only +1; pop only -1; push and pop together unchanged.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH naturally.

Upstream holding:
- in_valid high while in_ready is low is legal. The ALU holds the data, nothing is written, and the entry is not lost.

Sticky flags (per posedge, rst low):
- sticky_clr=1, push=1: sticky <= in_flags (new flags win over the clear).
- sticky_clr=1, push=0: sticky <= 0.
- sticky_clr=0, push=1: sticky <= sticky | in_flags.
- otherwise: hold.
- Pops never affect sticky_flags.

flag_irq:
- Registered; high for exactly the cycle after a push where (in_flags & IRQ_MASK & ~sticky_base) != 0.
- sticky_base is 0 when sticky_clr is asserted in that cycle, otherwise the current sticky_flags.
- Repeated occurrences of an already-sticky bit do not pulse.

Error and empty/full edges:
- Pop on empty is impossible because out_valid=0.
- Push when full is impossible because in_ready=0.
- Under these rules, count never leaves the range 0..DEPTH.

Test Plan:
- Single result, pipe to consumer: after reset, push 0x423AC000 with flags 0, out_ready=1. Required: out_valid rises one cycle later with out_result=0x423AC000 and out_flags=0; count goes 1 then 0; sticky_flags=0; flag_irq=0.
- Fill and backpressure: out_ready=0, push 0x423AC000, 0xC32B8000, 0x42861000, 0x42C24000, then hold in_valid with 0x7F800000. Required: count=4, in_ready=0, and the fifth word is not written. With out_ready=1, outputs come in the order 0x423AC000, 0xC32B8000, 0x42861000, 0x42C24000, 0x7F800000; in_ready returns one cycle after the first pop.
- Simultaneous push/pop at count=2 for 8 cycles with a streaming sequence. Required: count stays 2, order is preserved, pointers wrap with no loss or duplication.
- Sticky accumulation: push 0x3CA3D70B with flags 5'b10000, then 0x7F800000 with flags 5'b10100. Required: sticky_flags=5'b10100, and flag_irq pulses once (on the second push only). A third push of 0x7FC00000 with flags 5'b00001 pulses flag_irq again and leaves sticky=5'b10101.
- Clear collision: sticky=5'b10101, assert sticky_clr together with a push carrying flags 5'b00010. Required: sticky=5'b00010, and flag_irq=0 (U is not in the mask). A clear alone gives sticky=0.
- Reset mid-stream: with count=3 and in_valid=1, assert rst for one cycle. Required: in_ready=0 during reset; afterwards count=0, out_valid=0, sticky_flags=0, and the held input is accepted on the next cycle.
